// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Purpose:
//   Shares one MemorySystem port between two processors. One requester is
//   granted at a time using round-robin priority. The memory-side signals are
//   driven from registers. Each access is timed from the Hit/miss indication
//   sampled on the first WAIT edge. At the end of the access, read data and a
//   one-cycle Done pulse go back to the owner.
//
// Parameters:
//   HIT_LAT   wait cycles for an access reporting Hit  (1..15)
//   MISS_LAT  wait cycles for an access reporting miss (1..15)
//
// Ports:
//   Clk, Reset          clock; asynchronous active-high reset
//   Req0/Req1           level request per requester
//   RWB0/RWB1           1 = read, 0 = write
//   Addr0/Addr1         6-bit access address
//   WData0/WData1       8-bit write data
//   Gnt0/Gnt1           one-cycle grant pulse (ISSUE cycle)
//   Done0/Done1         one-cycle completion pulse (DONE cycle)
//   RData               data captured from the last completed access
//   MemRWB/MemAddr/
//   MemData             registered drive of the MemorySystem inputs
//   MemHit, MemOut      MemorySystem Hit and MemSysOut
//   HitCount/MissCount  saturating access statistics (MEM_ARB_STATS_EN only)
//
// Build option:
//   MEM_ARB_STATS_EN    when defined, adds HitCount/MissCount and their logic.
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int HIT_LAT  = 1,
  parameter int MISS_LAT = 4
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Req0,
  input  logic       Req1,
  input  logic       RWB0,
  input  logic       RWB1,
  input  logic [5:0] Addr0,
  input  logic [5:0] Addr1,
  input  logic [7:0] WData0,
  input  logic [7:0] WData1,
  output logic       Gnt0,
  output logic       Gnt1,
  output logic       Done0,
  output logic       Done1,
  output logic [7:0] RData,
  output logic       MemRWB,
  output logic [5:0] MemAddr,
  output logic [7:0] MemData,
`ifdef MEM_ARB_STATS_EN
  output logic [7:0] HitCount,
  output logic [7:0] MissCount,
`endif
  input  logic       MemHit,
  input  logic [7:0] MemOut
);

  localparam logic [3:0] HIT_LAT4  = 4'(HIT_LAT);
  localparam logic [3:0] MISS_LAT4 = 4'(MISS_LAT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_next;

  logic       r_last;       // requester granted most recently
  logic       r_owner;      // requester owning the access in flight
  logic       r_first;      // set during the first WAIT cycle
  logic       r_hit_r;      // Hit status latched on the first WAIT edge
  logic [3:0] r_cnt;        // remaining wait edges after the first one
  logic       r_gnt0;
  logic       r_gnt1;
  logic       r_done0;
  logic       r_done1;
  logic [7:0] r_rdata;
  logic       r_mem_rwb;
  logic [5:0] r_mem_addr;
  logic [7:0] r_mem_data;

  logic       w_win1;       // requester 1 wins arbitration this cycle
  logic       w_accept;     // IDLE -> ISSUE edge
  logic       w_capture;    // WAIT -> DONE edge
  logic       w_hit_cur;    // Hit status of the access in flight
  logic [3:0] w_lat;
  logic [3:0] w_cnt_eff;    // counter value considered at this WAIT edge

  // Requester 1 wins when it is the only requester, or on a tie when
  // requester 0 was served last (Last = 0).
  assign w_win1 = Req1 & (~Req0 | ~r_last);

  // On the first WAIT edge MemHit is live; later edges use the latched copy.
  assign w_hit_cur = r_first ? MemHit : r_hit_r;
  assign w_lat     = w_hit_cur ? HIT_LAT4 : MISS_LAT4;

  // The first WAIT edge sees the freshly loaded value (LAT-1), so LAT=1
  // samples Hit and captures data on that same edge.
  assign w_cnt_eff = r_first ? (w_lat - 4'd1) : r_cnt;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and control strobes
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (Req0 | Req1) begin
          w_accept     = 1'b1;
          w_state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_cnt_eff == 4'd0) begin
          w_capture    = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arbitration bookkeeping, handshakes and memory-side registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_first    <= 1'b0;
      r_hit_r    <= 1'b0;
      r_cnt      <= 4'd0;
      r_gnt0     <= 1'b0;
      r_gnt1     <= 1'b0;
      r_done0    <= 1'b0;
      r_done1    <= 1'b0;
      r_rdata    <= 8'd0;
      r_mem_rwb  <= 1'b1;
      r_mem_addr <= 6'd0;
      r_mem_data <= 8'd0;
    end else begin
      // Grant and Done are registered so each is high for exactly the ISSUE
      // and DONE cycle respectively; they can never overlap.
      r_gnt0  <= w_accept & ~w_win1;
      r_gnt1  <= w_accept &  w_win1;
      r_done0 <= w_capture & ~r_owner;
      r_done1 <= w_capture &  r_owner;

      if (w_accept) begin
        r_owner    <= w_win1;
        r_last     <= w_win1;
        r_mem_rwb  <= w_win1 ? RWB1   : RWB0;
        r_mem_addr <= w_win1 ? Addr1  : Addr0;
        r_mem_data <= w_win1 ? WData1 : WData0;
      end else if (r_state == S_DONE) begin
        // Park the port in read mode between accesses; address/data hold.
        r_mem_rwb <= 1'b1;
      end

      r_first <= (r_state == S_ISSUE);

      if (r_state == S_WAIT) begin
        if (r_first) begin
          r_hit_r <= MemHit;
        end
        if (w_cnt_eff != 4'd0) begin
          r_cnt <= w_cnt_eff - 4'd1;
        end else begin
          r_cnt <= 4'd0;
        end
      end

      // Captured for writes too; the value is simply unused by the requester.
      if (w_capture) begin
        r_rdata <= MemOut;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  // ---------------------------------------------------------------------------
  // Saturating hit/miss statistics, counted once per access on the first
  // WAIT edge.
  // ---------------------------------------------------------------------------
  logic [7:0] r_hit_count;
  logic [7:0] r_miss_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_hit_count  <= 8'd0;
      r_miss_count <= 8'd0;
    end else if ((r_state == S_WAIT) && r_first) begin
      if (w_hit_cur) begin
        if (r_hit_count != 8'hFF) begin
          r_hit_count <= r_hit_count + 8'd1;
        end
      end else begin
        if (r_miss_count != 8'hFF) begin
          r_miss_count <= r_miss_count + 8'd1;
        end
      end
    end
  end

  assign HitCount  = r_hit_count;
  assign MissCount = r_miss_count;
`endif

  assign Gnt0    = r_gnt0;
  assign Gnt1    = r_gnt1;
  assign Done0   = r_done0;
  assign Done1   = r_done1;
  assign RData   = r_rdata;
  assign MemRWB  = r_mem_rwb;
  assign MemAddr = r_mem_addr;
  assign MemData = r_mem_data;

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//
// Directed bench for mem_arbiter with default latencies (HIT_LAT=1,
// MISS_LAT=4). Inputs change and outputs are sampled 1 time unit after each
// rising edge. Statistics checks are compiled in with MEM_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Req0, Req1, RWB0, RWB1;
  logic [5:0] Addr0, Addr1;
  logic [7:0] WData0, WData1;
  logic       Gnt0, Gnt1, Done0, Done1;
  logic [7:0] RData;
  logic       MemRWB;
  logic [5:0] MemAddr;
  logic [7:0] MemData;
  logic       MemHit;
  logic [7:0] MemOut;
`ifdef MEM_ARB_STATS_EN
  logic [7:0] HitCount, MissCount;
`endif

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.HIT_LAT(1), .MISS_LAT(4)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Req0     (Req0),
    .Req1     (Req1),
    .RWB0     (RWB0),
    .RWB1     (RWB1),
    .Addr0    (Addr0),
    .Addr1    (Addr1),
    .WData0   (WData0),
    .WData1   (WData1),
    .Gnt0     (Gnt0),
    .Gnt1     (Gnt1),
    .Done0    (Done0),
    .Done1    (Done1),
    .RData    (RData),
    .MemRWB   (MemRWB),
    .MemAddr  (MemAddr),
    .MemData  (MemData),
`ifdef MEM_ARB_STATS_EN
    .HitCount (HitCount),
    .MissCount(MissCount),
`endif
    .MemHit   (MemHit),
    .MemOut   (MemOut)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_gnt"},  {30'd0, Gnt1, Gnt0}, 32'd0);
    chk({tag, "_done"}, {30'd0, Done1, Done0}, 32'd0);
    chk({tag, "_rdata"}, {24'd0, RData}, 32'd0);
    chk({tag, "_rwb"},  {31'd0, MemRWB}, 32'd1);
    chk({tag, "_addr"}, {26'd0, MemAddr}, 32'd0);
    chk({tag, "_wdata"}, {24'd0, MemData}, 32'd0);
  endtask

  initial begin
    Reset = 1'b1;
    Req0 = 0; Req1 = 0; RWB0 = 1; RWB1 = 1;
    Addr0 = 0; Addr1 = 0; WData0 = 0; WData1 = 0;
    MemHit = 1; MemOut = 0;
    #3;
    chk_reset_outputs("reset_init");
`ifdef MEM_ARB_STATS_EN
    chk("reset_hitcnt",  {24'd0, HitCount}, 32'd0);
    chk("reset_misscnt", {24'd0, MissCount}, 32'd0);
`endif
    tick();
    tick();
    Reset = 1'b0;
    tick();

    // ---------------- Single read, hit ----------------
    Req0 = 1; RWB0 = 1; Addr0 = 6'h05; WData0 = 8'h77; MemHit = 1; MemOut = 8'hA5;
    tick();                                   // cycle E+1
    chk("rd_gnt0", {31'd0, Gnt0}, 32'd1);
    chk("rd_gnt1", {31'd0, Gnt1}, 32'd0);
    chk("rd_addr", {26'd0, MemAddr}, 32'h05);
    chk("rd_rwb",  {31'd0, MemRWB}, 32'd1);
    Req0 = 0;
    tick();                                   // E+2 WAIT
    chk("rd_wait_gnt0",  {31'd0, Gnt0}, 32'd0);
    chk("rd_wait_done0", {31'd0, Done0}, 32'd0);
    tick();                                   // E+3 DONE
    chk("rd_done0", {31'd0, Done0}, 32'd1);
    chk("rd_done1", {31'd0, Done1}, 32'd0);
    chk("rd_rdata", {24'd0, RData}, 32'hA5);
    tick();                                   // IDLE
    chk("rd_after_done0", {31'd0, Done0}, 32'd0);
    chk("rd_after_rwb",   {31'd0, MemRWB}, 32'd1);
    chk("rd_after_addr",  {26'd0, MemAddr}, 32'h05);

    // ---------------- Single write, miss ----------------
    Req1 = 1; RWB1 = 0; Addr1 = 6'h3F; WData1 = 8'h3C; MemHit = 0; MemOut = 8'h11;
    tick();                                   // E+1
    chk("wr_gnt1",  {31'd0, Gnt1}, 32'd1);
    chk("wr_gnt0",  {31'd0, Gnt0}, 32'd0);
    chk("wr_rwb",   {31'd0, MemRWB}, 32'd0);
    chk("wr_wdata", {24'd0, MemData}, 32'h3C);
    chk("wr_addr",  {26'd0, MemAddr}, 32'h3F);
    Req1 = 0;
    for (int k = 1; k <= 4; k++) begin        // E+2 .. E+5 WAIT
      tick();
      chk($sformatf("wr_wait%0d_done1", k), {31'd0, Done1}, 32'd0);
      chk($sformatf("wr_wait%0d_rwb", k), {31'd0, MemRWB}, 32'd0);
    end
    tick();                                   // E+6 DONE
    chk("wr_done1", {31'd0, Done1}, 32'd1);
    chk("wr_done0", {31'd0, Done0}, 32'd0);
    chk("wr_done_rwb", {31'd0, MemRWB}, 32'd0);
    tick();                                   // IDLE
    chk("wr_after_done1", {31'd0, Done1}, 32'd0);
    chk("wr_after_rwb",   {31'd0, MemRWB}, 32'd1);
    chk("wr_after_wdata", {24'd0, MemData}, 32'h3C);

    // ---------------- Simultaneous requests, round robin ----------------
    Req0 = 1; Req1 = 1; RWB0 = 1; RWB1 = 1;
    Addr0 = 6'h0A; Addr1 = 6'h15; MemHit = 1; MemOut = 8'h3E;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("rr%0d_gnt0", i), {31'd0, Gnt0}, {31'd0, (i == 0 || i == 8)});
      chk($sformatf("rr%0d_gnt1", i), {31'd0, Gnt1}, {31'd0, (i == 4 || i == 12)});
      chk($sformatf("rr%0d_done0", i), {31'd0, Done0}, {31'd0, (i == 2 || i == 10)});
      chk($sformatf("rr%0d_done1", i), {31'd0, Done1}, {31'd0, (i == 6 || i == 14)});
      if (i == 0 || i == 8) chk($sformatf("rr%0d_addr", i), {26'd0, MemAddr}, 32'h0A);
      if (i == 4 || i == 12) chk($sformatf("rr%0d_addr", i), {26'd0, MemAddr}, 32'h15);
    end
    Req0 = 0; Req1 = 0;
    tick();
    chk("rr_stop_gnt", {30'd0, Gnt1, Gnt0}, 32'd0);

    // ---------------- Back-to-back single requester ----------------
    Req0 = 1; Addr0 = 6'h21; MemHit = 1; MemOut = 8'h96;
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("b2b%0d_gnt0", j), {31'd0, Gnt0}, {31'd0, (j == 0 || j == 4)});
      chk($sformatf("b2b%0d_done0", j), {31'd0, Done0}, {31'd0, (j == 2 || j == 6)});
      if (j == 4) Req0 = 0;
    end
    chk("b2b_rdata", {24'd0, RData}, 32'h96);

    // ---------------- Reset in the third WAIT cycle of a miss ----------------
    Req0 = 1; RWB0 = 1; Addr0 = 6'h0C; WData0 = 8'h5A; MemHit = 0; MemOut = 8'h44;
    tick();
    chk("rst_gnt0", {31'd0, Gnt0}, 32'd1);
    chk("rst_wdata_pre", {24'd0, MemData}, 32'h5A);
    Req0 = 0;
    tick();
    tick();
    tick();                                   // third WAIT cycle
    chk("rst_wait3_done0", {31'd0, Done0}, 32'd0);
    Reset = 1;
    #1;
    chk_reset_outputs("rst_async");
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("rst_hold%0d_done0", k), {31'd0, Done0}, 32'd0);
    end
    Reset = 0;
    tick();
    chk("rst_released_done0", {31'd0, Done0}, 32'd0);
    Req1 = 1; RWB1 = 1; Addr1 = 6'h2A; MemHit = 1; MemOut = 8'h5C;
    tick();
    chk("rst_req1_gnt1", {31'd0, Gnt1}, 32'd1);
    chk("rst_req1_addr", {26'd0, MemAddr}, 32'h2A);
    Req1 = 0;
    tick();
    tick();
    chk("rst_req1_done1", {31'd0, Done1}, 32'd1);
    chk("rst_req1_rdata", {24'd0, RData}, 32'h5C);
    tick();

    // ---------------- First tie after reset goes to requester 0 ----------------
    Reset = 1;
    tick();
    Reset = 0;
    tick();
    Req0 = 1; Req1 = 1; Addr0 = 6'h33; Addr1 = 6'h11; MemHit = 1; MemOut = 8'h69;
    tick();
    chk("tie_gnt0", {31'd0, Gnt0}, 32'd1);
    chk("tie_gnt1", {31'd0, Gnt1}, 32'd0);
    chk("tie_addr", {26'd0, MemAddr}, 32'h33);
    Req0 = 0; Req1 = 0;
    tick();
    tick();
    chk("tie_done0", {31'd0, Done0}, 32'd1);
    tick();

`ifdef MEM_ARB_STATS_EN
    // ---------------- Statistics saturation ----------------
    Reset = 1;
    tick();
    Reset = 0;
    tick();
    chk("st_hit_reset", {24'd0, HitCount}, 32'd0);
    MemHit = 1; RWB0 = 1;
    for (int n = 0; n < 300; n++) begin
      Req0 = 1;
      tick();
      Req0 = 0;
      tick();
      tick();
      tick();
    end
    MemHit = 0;
    for (int n = 0; n < 2; n++) begin
      Req0 = 1;
      tick();
      Req0 = 0;
      for (int k = 0; k < 6; k++) tick();
    end
    chk("st_hitcount",  {24'd0, HitCount}, 32'd255);
    chk("st_misscount", {24'd0, MissCount}, 32'd2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
